cordic_rotation_engine: RTL and testbench

- Iterative rotation-mode CORDIC core; computes Cordic_x ≈ cos(angle) and Cordic_y ≈ sin(angle) for a pre-reduced angle.
- Sits directly upstream of the post-processing (sign-correction) stage and feeds its Cordic_x_in, Cordic_y_in, Cos_negate_in and Sin_negate_in inputs.
- Quadrant negate flags from the pre-processing stage are carried alongside each sample.
- Processes one sample at a time, with valid/ready handshakes on input and output.

---
 rtl/cordic_rotation_engine.sv | 161 ++++++++++++++++
 tb/tb_cordic_rotation_engine.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_rotation_engine.sv
// Iterative rotation-mode CORDIC: one sample at a time, one micro-rotation per clock.
// Produces cos/sin magnitudes (Q1.14) of a pre-reduced Q2.13 angle. The quadrant negate
// flags travel with the sample.
module cordic_rotation_engine #(
    parameter int unsigned ITERATIONS = 14,
    parameter int unsigned GUARD      = 2
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        In_valid,
    output logic        In_ready,
    input  logic [15:0] Angle_in,
    input  logic        Cos_negate_in,
    input  logic        Sin_negate_in,
    output logic        Out_valid,
    input  logic        Out_ready,
    output logic [15:0] Cordic_x_out,
    output logic [15:0] Cordic_y_out,
    output logic        Cos_negate_out,
    output logic        Sin_negate_out
);

    localparam int unsigned W = 16 + GUARD;
    // K * 2^14 pre-scaled into the guard-extended x register.
    localparam logic signed [W-1:0] XInit    = W'(9949 * (2 ** GUARD));
    localparam logic [3:0]          LastIter = 4'(ITERATIONS - 1);

    typedef enum logic [1:0] {StIdle, StRotate, StDone} state_e;

    state_e               state_q, state_d;
    logic signed [W-1:0]  x_q, x_d, y_q, y_d;
    logic signed [15:0]   z_q, z_d;
    logic [3:0]           i_q, i_d;
    logic                 cneg_q, cneg_d, sneg_q, sneg_d;
    logic [15:0]          xo_q, xo_d, yo_q, yo_d;
    logic                 cno_q, cno_d, sno_q, sno_d;

    logic signed [W-1:0]  x_sh, y_sh, x_rot, y_rot;
    logic signed [15:0]   atan_v, z_rot;

    // arctan(2^-i) in Q2.13
    function automatic logic signed [15:0] atan_lut(input logic [3:0] idx);
        case (idx)
            4'd0:    atan_lut = 16'sd6434;
            4'd1:    atan_lut = 16'sd3798;
            4'd2:    atan_lut = 16'sd2007;
            4'd3:    atan_lut = 16'sd1019;
            4'd4:    atan_lut = 16'sd511;
            4'd5:    atan_lut = 16'sd256;
            4'd6:    atan_lut = 16'sd128;
            4'd7:    atan_lut = 16'sd64;
            4'd8:    atan_lut = 16'sd32;
            4'd9:    atan_lut = 16'sd16;
            4'd10:   atan_lut = 16'sd8;
            4'd11:   atan_lut = 16'sd4;
            4'd12:   atan_lut = 16'sd2;
            4'd13:   atan_lut = 16'sd1;
            default: atan_lut = 16'sd0;
        endcase
    endfunction

    // Next-state, micro-rotation datapath and handshake outputs
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        i_d     = i_q;
        cneg_d  = cneg_q;
        sneg_d  = sneg_q;
        xo_d    = xo_q;
        yo_d    = yo_q;
        cno_d   = cno_q;
        sno_d   = sno_q;

        x_sh   = x_q >>> i_q;
        y_sh   = y_q >>> i_q;
        atan_v = atan_lut(i_q);
        // Rotate toward zero residual angle: d = +1 when z >= 0.
        if (!z_q[15]) begin
            x_rot = x_q - y_sh;
            y_rot = y_q + x_sh;
            z_rot = z_q - atan_v;
        end else begin
            x_rot = x_q + y_sh;
            y_rot = y_q - x_sh;
            z_rot = z_q + atan_v;
        end

        case (state_q)
            StIdle: begin
                if (In_valid) begin
                    x_d     = XInit;
                    y_d     = '0;
                    z_d     = Angle_in;
                    i_d     = 4'd0;
                    cneg_d  = Cos_negate_in;
                    sneg_d  = Sin_negate_in;
                    state_d = StRotate;
                end
            end
            StRotate: begin
                x_d = x_rot;
                y_d = y_rot;
                z_d = z_rot;
                i_d = i_q + 4'd1;
                if (i_q == LastIter) begin
                    // Drop the guard bits (truncating) straight into the output registers.
                    xo_d    = x_rot[W-1:GUARD];
                    yo_d    = y_rot[W-1:GUARD];
                    cno_d   = cneg_q;
                    sno_d   = sneg_q;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (Out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        In_ready       = (state_q == StIdle);
        Out_valid      = (state_q == StDone);
        Cordic_x_out   = xo_q;
        Cordic_y_out   = yo_q;
        Cos_negate_out = cno_q;
        Sin_negate_out = sno_q;
    end

    // State and datapath registers; reset discards any in-flight sample
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= StIdle;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            i_q     <= '0;
            cneg_q  <= 1'b0;
            sneg_q  <= 1'b0;
            xo_q    <= '0;
            yo_q    <= '0;
            cno_q   <= 1'b0;
            sno_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            i_q     <= i_d;
            cneg_q  <= cneg_d;
            sneg_q  <= sneg_d;
            xo_q    <= xo_d;
            yo_q    <= yo_d;
            cno_q   <= cno_d;
            sno_q   <= sno_d;
        end
    end

endmodule

// File: tb/tb_cordic_rotation_engine.sv
// Directed + randomized bench for cordic_rotation_engine. Expected values come from an
// integer CORDIC model built from the algorithm definition and from real-valued cos/sin.
module tb_cordic_rotation_engine;

    localparam int ITER  = 14;
    localparam int GRD   = 2;
    localparam int LAT   = ITER + 1;  // edges counted from (and including) the accepting edge
    localparam real SCALE_IN  = 8192.0;
    localparam real SCALE_OUT = 16384.0;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        In_valid = 1'b0;
    logic        In_ready;
    logic [15:0] Angle_in = '0;
    logic        Cos_negate_in = 1'b0;
    logic        Sin_negate_in = 1'b0;
    logic        Out_valid;
    logic        Out_ready = 1'b0;
    logic [15:0] Cordic_x_out;
    logic [15:0] Cordic_y_out;
    logic        Cos_negate_out;
    logic        Sin_negate_out;

    int n_tests = 0;
    int n_fail  = 0;

    cordic_rotation_engine #(.ITERATIONS(ITER), .GUARD(GRD)) dut (
        .Clk            (Clk),
        .Rst            (Rst),
        .In_valid       (In_valid),
        .In_ready       (In_ready),
        .Angle_in       (Angle_in),
        .Cos_negate_in  (Cos_negate_in),
        .Sin_negate_in  (Sin_negate_in),
        .Out_valid      (Out_valid),
        .Out_ready      (Out_ready),
        .Cordic_x_out   (Cordic_x_out),
        .Cordic_y_out   (Cordic_y_out),
        .Cos_negate_out (Cos_negate_out),
        .Sin_negate_out (Sin_negate_out)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_tol(input string tag, input int obs, input real ideal);
        real diff;
        logic ok;
        diff = real'(obs) - ideal;
        ok = (diff <= 6.5) && (diff >= -6.5);
        n_tests++;
        assert (ok === 1'b1) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0f +/-6", tag, obs, ideal);
        end
    endtask

    // Reference: CORDIC rotation with plain integer arithmetic.
    function automatic void model(input int ang, output int xo, output int yo);
        int x, y, z, xn, yn;
        int atan_tab[14] = '{6434, 3798, 2007, 1019, 511, 256, 128, 64, 32, 16, 8, 4, 2, 1};
        x = 9949 * (1 << GRD);
        y = 0;
        z = ang;
        for (int i = 0; i < ITER; i++) begin
            if (z >= 0) begin
                xn = x - (y >>> i);
                yn = y + (x >>> i);
                z  = z - atan_tab[i];
            end else begin
                xn = x + (y >>> i);
                yn = y - (x >>> i);
                z  = z + atan_tab[i];
            end
            x = xn;
            y = yn;
        end
        xo = x >>> GRD;
        yo = y >>> GRD;
    endfunction

    // Present a sample for one edge (caller is on a negedge-safe point, away from posedge).
    task automatic accept(input int ang, input logic cn, input logic sn);
        @(negedge Clk);
        In_valid      = 1'b1;
        Angle_in      = 16'(ang);
        Cos_negate_in = cn;
        Sin_negate_in = sn;
        @(posedge Clk);
        #1;
        In_valid      = 1'b0;
        Cos_negate_in = 1'b0;
        Sin_negate_in = 1'b0;
    endtask

    // Count edges (accepting edge = 1) until Out_valid, bounded.
    task automatic wait_out(output int lat);
        lat = 1;
        while (!Out_valid && lat < 60) begin
            @(posedge Clk);
            #1;
            lat++;
        end
    endtask

    task automatic pop();
        @(negedge Clk);
        Out_ready = 1'b1;
        @(posedge Clk);
        #1;
        Out_ready = 1'b0;
        check("pop_out_valid", int'(Out_valid), 0);
        check("pop_in_ready", int'(In_ready), 1);
    endtask

    // Full transaction with model + accuracy checks.
    task automatic run(input string tag, input int ang, input logic cn, input logic sn);
        int lat, ex, ey;
        real a;
        accept(ang, cn, sn);
        wait_out(lat);
        model(ang, ex, ey);
        a = real'(ang) / SCALE_IN;
        check({tag, "_lat"}, lat, LAT);
        check({tag, "_x"}, int'($signed(Cordic_x_out)), ex);
        check({tag, "_y"}, int'($signed(Cordic_y_out)), ey);
        check_tol({tag, "_xacc"}, int'($signed(Cordic_x_out)), $cos(a) * SCALE_OUT);
        check_tol({tag, "_yacc"}, int'($signed(Cordic_y_out)), $sin(a) * SCALE_OUT);
        check({tag, "_cn"}, int'(Cos_negate_out), int'(cn));
        check({tag, "_sn"}, int'(Sin_negate_out), int'(sn));
    endtask

    initial begin
        int lat, ex, ey, ang, hx, hy;
        logic cn, sn;

        // Reset
        repeat (3) @(posedge Clk);
        #1;
        Rst = 1'b0;
        check("rst_in_ready", int'(In_ready), 1);
        check("rst_out_valid", int'(Out_valid), 0);
        check("rst_x", int'(Cordic_x_out), 0);
        check("rst_y", int'(Cordic_y_out), 0);
        check("rst_flags", int'({Cos_negate_out, Sin_negate_out}), 0);

        // Directed angles
        run("zero", 0, 1'b0, 1'b0);
        pop();
        run("pi4", 6434, 1'b0, 1'b1);
        check_tol("pi4_x_11585", int'($signed(Cordic_x_out)), 11585.0);
        check_tol("pi4_y_11585", int'($signed(Cordic_y_out)), 11585.0);
        pop();
        run("mpi2", -12868, 1'b1, 1'b0);
        check_tol("mpi2_x_0", int'($signed(Cordic_x_out)), 0.0);
        check_tol("mpi2_y_m16384", int'($signed(Cordic_y_out)), -16384.0);

        // Backpressure: result held for 10 cycles
        hx = int'(Cordic_x_out);
        hy = int'(Cordic_y_out);
        for (int k = 0; k < 10; k++) begin
            @(posedge Clk);
            #1;
            check("bp_valid", int'(Out_valid), 1);
            check("bp_in_ready", int'(In_ready), 0);
            check("bp_x", int'(Cordic_x_out), hx);
            check("bp_y", int'(Cordic_y_out), hy);
            check("bp_flags", int'({Cos_negate_out, Sin_negate_out}), 2);
        end
        pop();
        check("hold_x_after_pop", int'(Cordic_x_out), hx);

        // In_valid during ROTATE is ignored
        accept(3000, 1'b1, 1'b1);
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        In_valid = 1'b1;
        Angle_in = 16'(-9000);
        Cos_negate_in = 1'b0;
        Sin_negate_in = 1'b0;
        @(posedge Clk);
        #1;
        In_valid = 1'b0;
        check("ign_in_ready", int'(In_ready), 0);
        wait_out(lat);
        model(3000, ex, ey);
        check("ign_x", int'($signed(Cordic_x_out)), ex);
        check("ign_y", int'($signed(Cordic_y_out)), ey);
        check("ign_flags", int'({Cos_negate_out, Sin_negate_out}), 3);
        pop();

        // Reset at iteration 5
        accept(8000, 1'b1, 1'b0);
        repeat (5) @(posedge Clk);
        #1;
        Rst = 1'b1;
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        check("mrst_in_ready", int'(In_ready), 1);
        check("mrst_out_valid", int'(Out_valid), 0);
        check("mrst_x", int'(Cordic_x_out), 0);
        check("mrst_y", int'(Cordic_y_out), 0);
        check("mrst_flags", int'({Cos_negate_out, Sin_negate_out}), 0);
        run("after_rst", -5000, 1'b0, 1'b1);
        pop();

        // Randomized legal angles, random pop delay
        for (int n = 0; n < 24; n++) begin
            ang = int'($urandom_range(25736, 0)) - 12868;
            cn  = 1'($urandom_range(1, 0));
            sn  = 1'($urandom_range(1, 0));
            run("rand", ang, cn, sn);
            repeat ($urandom_range(3, 0)) @(posedge Clk);
            pop();
        end

        // Out-of-range angle must still complete
        accept(30000, 1'b0, 1'b0);
        wait_out(lat);
        check("oor_lat", lat, LAT);
        pop();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
